dram_arbiter: RTL and testbench
===============================

# dram_arbiter

- Sits directly upstream of the DRAM memory controller.
- Takes read, write and broadcast requests from the four cores and arbitrates between them round-robin.
- Drives the 4-bit `mode` word the memory controller decodes, holding it stable for a fixed DRAM access window.
- Returns one-hot grant and done handshakes to the cores.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 3: cycles `mode` is held per access; legal range 1–15.

Ports:
- `clock`  in  1  — single clock; all state changes on its rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `rd_req`  in  4  — bit i: core i+1 requests a DRAM read; level, held until `done[i]`.
- `wr_req`  in  4  — bit i: core i+1 requests a write through its bus; level, held until `done[i]`.
- `bcast_req`  in  1  — core 1 requests a broadcast read to all cores.
- `end_process`  in  3  — bit j: core j+2 has finished; masks its requests.
- `mode`  out  4  — controller select:
  - 0 = broadcast read;
  - 1–4 = read by core 1–4;
  - 5–8 = write by core 1–4;
  - 15 = idle.
- `grant`  out  4  — one-hot core currently owning DRAM; 4'b1111 during broadcast.
- `done`  out  4  — one-cycle pulse to the core whose access just finished.
- `busy`  out  1  — high in ACCESS and RELEASE.

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- **IDLE:** evaluate requests each cycle. If any request is eligible, latch the winner, load the counter with `ACCESS_CYCLES-1` and go to ACCESS. Otherwise stay in IDLE with `mode`=15.
- **Eligibility:**
  - Core 1 is always eligible.
  - Core k (k = 2..4) is eligible only if `end_process[k-2]`=0.
- **Priority:**
  1. `bcast_req` beats everything.
  2. Otherwise round-robin over cores with `rd_req|wr_req`, searching from pointer `rr_ptr` (2 bits).
- **Read vs write:** if the winning core has both `rd_req` and `wr_req` set, write wins; its read is served on a later grant.
- **Pointer update:**
  - After a core-k grant, `rr_ptr` becomes (k mod 4), i.e. the next core.
  - A broadcast leaves `rr_ptr` unchanged.
  - Reset value of `rr_ptr` is 0 (core 1 first).
- **ACCESS:** `mode` and `grant` are held constant. The counter decrements each cycle; when it reaches 0, go to RELEASE.
  - Request deassertion or `end_process` rising mid-access does not abort the access.
- **RELEASE:** one cycle.
  - `mode`=15, `grant`=0.
  - `done` pulses for the winning core; broadcast pulses `done[0]`.
  - Next state is IDLE.
- **Mode arithmetic:** read = core index (1–4); write = core index + 4; broadcast = 0. No other codes other than 15 are ever driven.

## Timing
- **Reset (asynchronous):**
  - State = IDLE, `mode`=4'd15, `grant`=0, `done`=0, `busy`=0.
  - Counter = 0, `rr_ptr`=0.
  - Reset asserted mid-access forces these values immediately; nothing is replayed after reset release.
- All outputs are registered.
- **Request to mode latency:** a request sampled in IDLE at edge N gives `mode`/`grant` valid from edge N+1, held for exactly `ACCESS_CYCLES` cycles.
- `done` is high for the cycle after the last ACCESS cycle.
- **Occupancy:** minimum occupancy per access is `ACCESS_CYCLES`+2 cycles (ACCESS + RELEASE + IDLE evaluation).
- A core that keeps requesting after `done` is re-eligible at the next IDLE, but its round-robin turn is behind the other requesting cores.
- **Simultaneous events:**
  - `bcast_req` together with core requests: the broadcast is served first.
  - Request and `end_process` asserted in the same cycle: the request is masked.
- **Latency bounds:**
  - Starvation bound for an eligible core with no broadcast: at most 3 accesses by other cores before its own.
  - Broadcast can starve the others; core 1 software must bound it.

## Structure
- Shared package `mc_pkg`:
  - mode constants `MODE_BCAST`=0, `MODE_RD_BASE`=0, `MODE_WR_BASE`=4, `MODE_IDLE`=15;
  - state encoding for the FSM.
- The memory controller imports the same mode constants from `mc_pkg`.
- One sub-module, `rr_pick4`: combinational; inputs a 4-bit request vector and the pointer, outputs a one-hot winner plus a valid flag.
- Counter, pointer and FSM live in the top module.

## Test plan
- **Reset:** pulse `rst_n` low mid-ACCESS with `mode`=6 → `mode`=15, `grant`=0, `busy`=0 immediately, asynchronous to `clock`.
- **Single read, `ACCESS_CYCLES`=3:** `rd_req`=4'b0100 at edge 0 → `mode`=3, `grant`=4'b0100 on edges 1–3; RELEASE with `done`=4'b0100 and `mode`=15 on edge 4.
- **Round-robin:** `rd_req`=4'b1111 held → grants in order core1, core2, core3, core4, core1; every access uses the read mode.
- **Write priority and mask:**
  - `rd_req`=`wr_req`=4'b0001 → `mode`=5.
  - `wr_req`=4'b0010 with `end_process`=3'b001 → core 2 is never granted and `mode` stays 15.
- **Broadcast:** `bcast_req`=1 with `rd_req`=4'b1000 → `mode`=0 and `grant`=4'b1111 first, `done`=4'b0001; then `mode`=4 for core 4; `rr_ptr` is unchanged by the broadcast.
- **Abort-free access:** deassert `rd_req` and raise `end_process` during ACCESS → `mode` held for the full `ACCESS_CYCLES`, and `done` still pulses.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions between the DRAM arbiter and the memory controller:
// mode codes the controller decodes and the arbiter FSM state encoding.
package mc_pkg;

    localparam logic [3:0] MODE_BCAST   = 4'd0;
    localparam logic [3:0] MODE_RD_BASE = 4'd0;
    localparam logic [3:0] MODE_WR_BASE = 4'd4;
    localparam logic [3:0] MODE_IDLE    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or after ptr,
// wrapping around, returned one-hot with a valid flag.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       vld
);

    logic [1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = ptr;
        for (int j = 0; j < 4; j++) begin
            idx = ptr + 2'(j);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter in front of the DRAM controller: grants one core (or a
// core-1 broadcast) and holds the controller mode for ACCESS_CYCLES cycles.
module dram_arbiter
    import mc_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [3:0] rd_req,
    input  logic [3:0] wr_req,
    input  logic       bcast_req,
    input  logic [2:0] end_process,
    output logic [3:0] mode,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       busy
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    arb_state_e state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [1:0] rr_ptr, rr_ptr_d;
    logic [3:0] win_mode, win_mode_d;
    logic [3:0] win_grant, win_grant_d;
    logic [3:0] win_done, win_done_d;

    logic [3:0] mode_d, grant_d, done_d;
    logic       busy_d;

    logic [3:0] eligible, core_req, pick_oh;
    logic       pick_vld;
    logic [1:0] pick_idx;

    // Core 1 can never be retired; cores 2..4 drop out once finished.
    assign eligible = {~end_process, 1'b1};
    assign core_req = (rd_req | wr_req) & eligible;

    rr_pick4 u_pick (
        .req (core_req),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .vld (pick_vld)
    );

    assign pick_idx = oh_to_idx(pick_oh);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            win_mode  <= MODE_IDLE;
            win_grant <= '0;
            win_done  <= '0;
            mode      <= MODE_IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rr_ptr    <= rr_ptr_d;
            win_mode  <= win_mode_d;
            win_grant <= win_grant_d;
            win_done  <= win_done_d;
            mode      <= mode_d;
            grant     <= grant_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rr_ptr_d    = rr_ptr;
        win_mode_d  = win_mode;
        win_grant_d = win_grant;
        win_done_d  = win_done;
        case (state)
            ST_IDLE: begin
                if (bcast_req) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = CNT_LOAD;
                    win_mode_d  = MODE_BCAST;
                    win_grant_d = 4'b1111;
                    win_done_d  = 4'b0001;
                end else if (pick_vld) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = CNT_LOAD;
                    // A core asking for both gets its write first.
                    win_mode_d  = (|(wr_req & pick_oh) ? MODE_WR_BASE : MODE_RD_BASE)
                                  + {2'b00, pick_idx} + 4'd1;
                    win_grant_d = pick_oh;
                    win_done_d  = pick_oh;
                    rr_ptr_d    = pick_idx + 2'd1;
                end
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) state_d = ST_RELEASE;
                else             cnt_d   = cnt - 4'd1;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        mode_d  = MODE_IDLE;
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        case (state_d)
            ST_ACCESS: begin
                mode_d  = win_mode_d;
                grant_d = win_grant_d;
                busy_d  = 1'b1;
            end
            ST_RELEASE: begin
                done_d = win_done_d;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level expectation queue.
module tb_dram_arbiter;

    localparam int AC = 3;

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] rd_req = '0;
    logic [3:0] wr_req = '0;
    logic       bcast_req = 1'b0;
    logic [2:0] end_process = '0;
    logic [3:0] mode, grant, done;
    logic       busy;

    dram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .bcast_req   (bcast_req),
        .end_process (end_process),
        .mode        (mode),
        .grant       (grant),
        .done        (done),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] mode;
        logic [3:0] grant;
        logic [3:0] done;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   ptr;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   pend;
    bit   last_rel;
    bit   rand_en = 1'b0;
    int   srv_core;
    bit   srv_wr;
    bit   srv_bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One granted transaction = AC cycles of held mode, then a done cycle.
    task automatic model_eval();
        logic [3:0] msk;
        int         win;
        exp_t       e;
        msk = {end_process, 1'b0};
        win = -1;
        if (bcast_req) begin
            e = '{mode: 4'd0, grant: 4'b1111, done: 4'd0, busy: 1'b1};
            srv_bc = 1'b1;
            for (int i = 0; i < AC; i++) q.push_back(e);
            q.push_back('{mode: 4'd15, grant: 4'd0, done: 4'b0001, busy: 1'b1});
        end else begin
            for (int j = 0; j < 4; j++) begin
                int k;
                k = (ptr + j) % 4;
                if (win < 0 && (rd_req[k] || wr_req[k]) && !msk[k]) win = k;
            end
            if (win >= 0) begin
                srv_bc   = 1'b0;
                srv_core = win;
                srv_wr   = wr_req[win];
                e.mode   = 4'(srv_wr ? 5 + win : 1 + win);
                e.grant  = 4'(1 << win);
                e.done   = 4'd0;
                e.busy   = 1'b1;
                for (int i = 0; i < AC; i++) q.push_back(e);
                q.push_back('{mode: 4'd15, grant: 4'd0, done: 4'(1 << win), busy: 1'b1});
                ptr = (win + 1) % 4;
            end
        end
    endtask

    task automatic stim(input bit eval, input bit rel);
        if (rel && ($urandom % 4 != 0)) begin
            if (srv_bc)      bcast_req = 1'b0;
            else if (srv_wr) wr_req[srv_core] = 1'b0;
            else             rd_req[srv_core] = 1'b0;
        end
        if (eval) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom % 6 == 0) rd_req[k] = 1'b1;
                if ($urandom % 7 == 0) wr_req[k] = 1'b1;
            end
            if ($urandom % 12 == 0) bcast_req = 1'b1;
            if ($urandom % 8 == 0)  end_process = 3'($urandom);
        end else if ($urandom % 16 == 0) begin
            end_process = 3'($urandom);
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit   eval;
        if (pend) model_eval();
        pend = 1'b0;
        @(negedge clock);
        eval = (q.size() == 0);
        if (eval) e = '{mode: 4'd15, grant: 4'd0, done: 4'd0, busy: 1'b0};
        else      e = q.pop_front();
        chk("mode", 32'(mode), 32'(e.mode));
        chk("grant", 32'(grant), 32'(e.grant));
        chk("done", 32'(done), 32'(e.done));
        chk("busy", 32'(busy), 32'(e.busy));
        last_rel = (e.done != 4'd0);
        if (rand_en) stim(eval, last_rel);
        pend = eval;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (last_rel) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rd_req = '0; wr_req = '0; bcast_req = 1'b0; end_process = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_mode", 32'(mode), 32'd15);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        q.delete();
        ptr  = 0;
        pend = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();

        // Single read by core 3.
        rd_req = 4'b0100;
        cycle();
        chk("rd3_mode", 32'(mode), 32'd3);
        chk("rd3_grant", 32'(grant), 32'b0100);
        run_until_done();
        chk("rd3_done", 32'(done), 32'b0100);
        rd_req = '0;
        run(2);

        // Round-robin over all four readers from a fresh pointer.
        do_reset();
        rd_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cycle();
            chk("rr_grant", 32'(grant), 32'(1 << (g % 4)));
            chk("rr_mode", 32'(mode), 32'((g % 4) + 1));
            run_until_done();
            cycle();
        end
        rd_req = '0;
        run(2);

        // Write beats read for the same core; read follows.
        rd_req = 4'b0001; wr_req = 4'b0001;
        cycle();
        chk("wr1_mode", 32'(mode), 32'd5);
        run_until_done();
        wr_req = '0;
        cycle();
        cycle();
        chk("rd1_mode", 32'(mode), 32'd1);
        run_until_done();
        rd_req = '0;
        cycle();

        // Finished core is masked even when request arrives with end_process.
        end_process = 3'b001; wr_req = 4'b0010;
        run(8);
        chk("mask_mode", 32'(mode), 32'd15);
        chk("mask_grant", 32'(grant), 32'd0);
        wr_req = '0; end_process = '0;
        run(1);

        // Broadcast first, then core 4.
        bcast_req = 1'b1; rd_req = 4'b1000;
        cycle();
        chk("bc_mode", 32'(mode), 32'd0);
        chk("bc_grant", 32'(grant), 32'b1111);
        run_until_done();
        chk("bc_done", 32'(done), 32'b0001);
        bcast_req = 1'b0;
        cycle();
        cycle();
        chk("bc_rd4_mode", 32'(mode), 32'd4);
        run_until_done();
        rd_req = '0;
        run(1);

        // Dropping the request and retiring the core mid-access does not abort it.
        rd_req = 4'b0010;
        cycle();
        rd_req = '0; end_process = 3'b001;
        run_until_done();
        chk("noabort_done", 32'(done), 32'b0010);
        end_process = '0;
        run(2);

        // Asynchronous reset in the middle of a core-2 write.
        wr_req = 4'b0010;
        cycle();
        chk("pre_rst_mode", 32'(mode), 32'd6);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mode", 32'(mode), 32'd15);
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        do_reset();
        run(3);

        // Random traffic.
        rand_en = 1'b1;
        run(800);
        rand_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
